clk_duty_meter: RTL and testbench

Synthesizable measuring end of the team's clock/PWM generation tasks. It samples an external waveform `sig_in` with the system clock and measures its high time, low time and period in `clk` cycles. It also computes the duty cycle as an 8-bit fraction and flags a stalled input. Used on-chip and in benches to check that a generated clock meets its programmed period and duty cycle.

---
 rtl/clk_meas_pkg.sv | 14 +
 rtl/frac_div8.sv | 71 +++++++
 rtl/clk_duty_meter.sv | 162 ++++++++++++++++
 tb/tb_clk_duty_meter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock duty-cycle meter.
// The state encoding is also what the top exposes on dbg_state.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DUTY_W    = 8;
    localparam int DIV_STEPS = 8;

endpackage

// File: rtl/frac_div8.sv
// Sequential restoring divider producing the 8-bit fraction num/den.
// Callers must guarantee num < den so the quotient fits in DUTY_W bits.
import clk_meas_pkg::*;

module frac_div8 #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W:0]    den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] q
);

    localparam int STEP_W = $clog2(DIV_STEPS);

    logic                r_busy;
    logic [STEP_W-1:0]   r_step;
    logic [CNT_W:0]      r_rem;
    logic [CNT_W:0]      r_den;
    logic [DUTY_W-1:0]   r_q;

    logic [CNT_W+1:0]    w_rem_sh;
    logic                w_ge;
    logic [CNT_W:0]      w_rem_nxt;
    logic [DUTY_W-1:0]   w_q_nxt;
    logic                w_last;

    // The remainder stays below den between steps, so one extra bit
    // is only needed for the shifted value.
    assign w_rem_sh  = {r_rem, 1'b0};
    assign w_ge      = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_nxt = w_ge ? (CNT_W+1)'(w_rem_sh - {1'b0, r_den})
                            : (CNT_W+1)'(w_rem_sh);
    assign w_q_nxt   = {r_q[DUTY_W-2:0], w_ge};
    assign w_last    = (r_step == STEP_W'(DIV_STEPS - 1));

    assign busy = r_busy;
    assign done = r_busy & w_last & ~abort;
    assign q    = w_q_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_step <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_q    <= '0;
        end else if (abort) begin
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_busy <= 1'b1;
            r_step <= '0;
            r_rem  <= {1'b0, num};
            r_den  <= den;
            r_q    <= '0;
        end else if (r_busy) begin
            r_rem  <= w_rem_nxt;
            r_q    <= w_q_nxt;
            r_step <= r_step + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_duty_meter.sv
// Measures high time, low time, period and duty of an asynchronous
// waveform in clk cycles, and flags a stalled input.
import clk_meas_pkg::*;

module clk_duty_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  ton_cnt,
    output logic [CNT_W-1:0]  toff_cnt,
    output logic [CNT_W:0]    period_cnt,
    output logic [DUTY_W-1:0] duty_q8,
    output logic              meas_valid,
    output logic              stuck,
    output logic              stuck_level,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    logic              r_s1, r_s2, r_s3;
    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_hi_cnt, r_lo_cnt, r_pend_hi, r_pend_lo, r_idle_cnt;
    logic [CNT_W-1:0]  r_ton, r_toff;
    logic [CNT_W:0]    r_period;
    logic [DUTY_W-1:0] r_duty;
    logic              r_valid, r_stuck, r_stuck_level, r_overrun;

    logic              w_rise, w_fall, w_edge, w_timeout;
    logic              w_close, w_start, w_drop;
    logic              w_div_busy, w_div_done;
    logic [DUTY_W-1:0] w_div_q;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_edge    = w_rise | w_fall;
    // An edge in the same cycle always wins over the stall timeout.
    assign w_timeout = ~w_edge && (r_idle_cnt == CNT_W'(TIMEOUT - 1));
    assign w_close   = w_rise && (r_state == LOW);
    assign w_start   = w_close & ~w_div_busy;
    assign w_drop    = w_close & w_div_busy;

    frac_div8 #(.CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .abort (w_timeout),
        .num   (r_hi_cnt),
        .den   ({1'b0, r_hi_cnt} + {1'b0, r_lo_cnt}),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .q     (w_div_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_rise) w_state_nxt = HIGH;
                HIGH:    if (w_fall) w_state_nxt = LOW;
                LOW:     if (w_rise) w_state_nxt = HIGH;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_hi_cnt   <= '0;
            r_lo_cnt   <= '0;
            r_pend_hi  <= '0;
            r_pend_lo  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            // Each counter includes the edge cycle that starts its phase.
            if (w_rise && r_state != HIGH) begin
                r_hi_cnt <= CNT_W'(1);
            end else if (r_state == HIGH && !w_fall) begin
                r_hi_cnt <= r_hi_cnt + 1'b1;
            end

            if (w_fall && r_state == HIGH) begin
                r_lo_cnt <= CNT_W'(1);
            end else if (r_state == LOW && !w_rise) begin
                r_lo_cnt <= r_lo_cnt + 1'b1;
            end

            if (w_start) begin
                r_pend_hi <= r_hi_cnt;
                r_pend_lo <= r_lo_cnt;
            end

            if (w_edge) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != CNT_W'(TIMEOUT)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ton         <= '0;
            r_toff        <= '0;
            r_period      <= '0;
            r_duty        <= '0;
            r_valid       <= 1'b0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_valid <= w_div_done;
            if (w_div_done) begin
                r_ton    <= r_pend_hi;
                r_toff   <= r_pend_lo;
                r_period <= {1'b0, r_pend_hi} + {1'b0, r_pend_lo};
                r_duty   <= w_div_q;
            end

            if (w_rise) begin
                r_stuck <= 1'b0;
            end else if (w_timeout) begin
                r_stuck       <= 1'b1;
                r_stuck_level <= r_s2;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign ton_cnt     = r_ton;
    assign toff_cnt    = r_toff;
    assign period_cnt  = r_period;
    assign duty_q8     = r_duty;
    assign meas_valid  = r_valid;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuck_level;
    assign overrun     = r_overrun;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_clk_duty_meter.sv
// Directed bench for clk_duty_meter: waveform driver, result scoreboard
// with expected-cycle tracking, and a final pass count.
module tb_clk_duty_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;
    localparam int RES_W   = 16 + 16 + 17 + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] ton_cnt, toff_cnt;
    logic [CNT_W:0]   period_cnt;
    logic [7:0]       duty_q8;
    logic             meas_valid, stuck, stuck_level, overrun;
    logic [1:0]       dbg_state;

    // Clock and cycle index (cycle k is the interval after the k-th posedge).
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    clk_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .ton_cnt     (ton_cnt),
        .toff_cnt    (toff_cnt),
        .period_cnt  (period_cnt),
        .duty_q8     (duty_q8),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    int               n_checks  = 0;
    int               n_pass    = 0;
    int               mon_mode  = 0;  // 0 scoreboard, 1 fixed 2/3 value, 2 count only
    int               valid_cnt = 0;
    logic [RES_W-1:0] exp_q[$];
    int               exp_t_q[$];
    logic [RES_W-1:0] mon_e;
    int               mon_t;
    int               r_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [RES_W-1:0] pack_res(input int hi, input int lo);
        int per;
        int duty;
        per  = hi + lo;
        duty = (hi * 256) / per;
        return {16'(hi), 16'(lo), 17'(per), 8'(duty)};
    endfunction

    // Scoreboard: every meas_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            valid_cnt++;
            if (mon_mode == 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = exp_t_q.pop_front();
                    check("result", 64'({ton_cnt, toff_cnt, period_cnt, duty_q8}), 64'(mon_e));
                    check("valid_cycle", 64'(cyc), 64'(mon_t));
                end
            end else if (mon_mode == 1) begin
                check("ovr_result", 64'({ton_cnt, toff_cnt, period_cnt, duty_q8}),
                      64'(pack_res(2, 3)));
            end
        end
    end

    // Driver tasks: all called at a negedge, inputs change only there.
    task automatic do_reset();
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Rise seen by the DUT two cycles after the drive; result nine after that.
    task automatic wave(input int hi, input int lo, input int n, input bit report_first);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            if ((i > 0 || report_first) && mon_mode == 0) begin
                exp_q.push_back(pack_res(hi, lo));
                exp_t_q.push_back(cyc + 2 + 9);
            end
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        exp_t_q.delete();
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({ton_cnt, toff_cnt, period_cnt, duty_q8, meas_valid,
                                  stuck, stuck_level, overrun}), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        rst = 1'b0;

        // 50 % duty
        wave(20, 20, 4, 1'b0);
        drain();
        check("duty_50", 64'(duty_q8), 64'(128));
        check("period_50", 64'(period_cnt), 64'(40));
        check("no_ovr_50", 64'(overrun), 64'(0));

        // skewed duty
        do_reset();
        wave(10, 30, 3, 1'b0);
        drain();
        check("duty_25", 64'(duty_q8), 64'(64));
        check("period_25", 64'(period_cnt), 64'(40));
        do_reset();
        wave(1, 39, 3, 1'b0);
        drain();
        check("duty_1_40", 64'(duty_q8), 64'(6));
        check("ton_1_40", 64'(ton_cnt), 64'(1));

        // overrun: period 5, accepted on every other closing rise
        do_reset();
        mon_mode  = 1;
        valid_cnt = 0;
        wave(2, 3, 20, 1'b0);
        repeat (12) @(negedge clk);
        check("ovr_set", 64'(overrun), 64'(1));
        check("ovr_reports", 64'(valid_cnt), 64'(10));
        check("ovr_duty", 64'(duty_q8), 64'(102));
        repeat (10) @(negedge clk);
        check("ovr_sticky", 64'(overrun), 64'(1));
        mon_mode = 0;

        // exact 9-cycle boundary
        do_reset();
        wave(4, 5, 8, 1'b0);
        drain();
        check("b9_overrun", 64'(overrun), 64'(0));
        check("b9_duty", 64'(duty_q8), 64'(113));
        check("b9_period", 64'(period_cnt), 64'(9));

        // stall: hold high after a closing rise
        do_reset();
        wave(20, 20, 3, 1'b0);
        sig_in = 1'b1;
        r_cyc  = cyc + 2;
        exp_q.push_back(pack_res(20, 20));
        exp_t_q.push_back(r_cyc + 9);
        while (cyc < r_cyc + TIMEOUT) @(negedge clk);
        check("stuck_not_yet", 64'(stuck), 64'(0));
        @(negedge clk);
        check("stuck_set", 64'(stuck), 64'(1));
        check("stuck_level", 64'(stuck_level), 64'(1));
        check("stuck_state", 64'(dbg_state), 64'(0));
        check("stuck_hold", 64'({ton_cnt, toff_cnt, period_cnt, duty_q8}), 64'(pack_res(20, 20)));
        sig_in = 1'b0;
        repeat (20) @(negedge clk);
        check("stuck_after_fall", 64'(stuck), 64'(1));
        wave(20, 20, 3, 1'b0);
        drain();
        check("stuck_cleared", 64'(stuck), 64'(0));

        // reset in the middle of a division
        do_reset();
        wave(20, 20, 2, 1'b0);
        drain();
        mon_mode  = 2;
        valid_cnt = 0;
        sig_in    = 1'b1;
        r_cyc     = cyc + 2;
        while (cyc < r_cyc + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", 64'({ton_cnt, toff_cnt, period_cnt, duty_q8, meas_valid,
                                      stuck, stuck_level, overrun}), 64'(0));
        check("rst_mid_state", 64'(dbg_state), 64'(0));
        rst    = 1'b0;
        sig_in = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_mid_no_valid", 64'(valid_cnt), 64'(0));
        mon_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
